// File: rtl/inst_seq_pkg.sv
// Shared state encoding, instruction class codes and class decode helpers
// for the nlp16 instruction sequencer.
package inst_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_F1   = 4'd1,
        ST_F2   = 4'd2,
        ST_DEC  = 4'd3,
        ST_EXEC = 4'd4,
        ST_MEM  = 4'd5,
        ST_WB   = 4'd6,
        ST_HALT = 4'd7,
        ST_ERR  = 4'd8
    } state_t;

    localparam logic [3:0] CLS_NOP    = 4'h0;
    localparam logic [3:0] CLS_ALU_RR = 4'h1;
    localparam logic [3:0] CLS_ALU_RI = 4'h2;
    localparam logic [3:0] CLS_LOAD   = 4'h3;
    localparam logic [3:0] CLS_STORE  = 4'h4;
    localparam logic [3:0] CLS_HALT   = 4'hF;

    function automatic logic is_two_word(input logic [3:0] cls);
        return (cls == CLS_ALU_RR) || (cls == CLS_ALU_RI) ||
               (cls == CLS_LOAD)   || (cls == CLS_STORE);
    endfunction

    function automatic logic is_legal(input logic [3:0] cls);
        return is_two_word(cls) || (cls == CLS_NOP) || (cls == CLS_HALT);
    endfunction

    // Register-immediate ALU ops select the all-ones source as the immediate port.
    function automatic logic s2_is_imm(input logic [3:0] cls);
        return cls == CLS_ALU_RI;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Purpose: counts consecutive memory wait cycles, flags the TIMEOUT-th one.
// Latency: expired is combinational on the cycle that completes the last wait.
// Backpressure: none; en/clr are qualified by the caller (stall already removed).
module wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic en,
    input  logic clr,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_tie;
            assign unused_tie = en ^ clr ^ i_clk ^ i_rst_n;
            assign expired    = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (en) begin
                    cnt <= cnt + CW'(1);
                end
            end

            // Independent of clr so the FSM next-state path stays loop free.
            assign expired = en && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/inst_sequencer.sv
// Purpose: fetches 1-2 instruction words, decodes, emits ALU/regfile/memory control.
// Latency: zero-wait F1->F1 is NOP 2, ALU 4, LOAD 5, STORE 4 cycles.
// Backpressure: i_mem_rdy stretches F1/F2/MEM (timeout to ERR); i_stall freezes and gates strobes.
module inst_sequencer
    import inst_seq_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 4,
    parameter int OP_W    = 6,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_mem_rdy,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic              o_mem_req,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic              o_pc_inc,
    output logic [3:0]        o_state,
    output logic              o_err,
    output logic              o_halt,
    output logic [OP_W-1:0]   o_alu_op,
    output logic [REG_W-1:0]  o_s1,
    output logic [REG_W-1:0]  o_s2,
    output logic [REG_W-1:0]  o_dest,
    output logic [DATA_W-1:0] o_imm,
    output logic              o_reg_we
);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] ir1, ir2;
    logic [3:0]        cls, func, in_cls;
    logic [REG_W-1:0]  dest, s1;
    logic              req_raw, xfer, wait_cyc, tmo, timer_clr;

    assign cls    = ir1[DATA_W-1 -: 4];
    assign func   = ir1[DATA_W-5 -: 4];
    assign dest   = ir1[DATA_W-9 -: REG_W];
    assign s1     = ir1[DATA_W-9-REG_W -: REG_W];
    assign in_cls = i_mem_data[DATA_W-1 -: 4];

    assign req_raw   = (state == ST_F1) || (state == ST_F2) || (state == ST_MEM);
    assign xfer      = req_raw && i_mem_rdy && !i_stall;
    assign wait_cyc  = req_raw && !i_mem_rdy && !i_stall;
    assign timer_clr = xfer || (state_nxt != state);

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .en      (wait_cyc),
        .clr     (timer_clr),
        .expired (tmo)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            ir1   <= '0;
            ir2   <= '0;
        end else begin
            state <= state_nxt;
            if (xfer && state == ST_F1) ir1 <= i_mem_data;
            if (xfer && state == ST_F2) ir2 <= i_mem_data;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (!i_stall) state_nxt = ST_F1;
            ST_F1: begin
                if (xfer)     state_nxt = is_two_word(in_cls) ? ST_F2 : ST_DEC;
                else if (tmo) state_nxt = ST_ERR;
            end
            ST_F2: begin
                if (xfer)     state_nxt = ST_DEC;
                else if (tmo) state_nxt = ST_ERR;
            end
            ST_DEC: begin
                if (!i_stall) begin
                    if (!is_legal(cls))                            state_nxt = ST_ERR;
                    else if (cls == CLS_NOP)                       state_nxt = ST_F1;
                    else if (cls == CLS_HALT)                      state_nxt = ST_HALT;
                    else if (cls == CLS_LOAD || cls == CLS_STORE)  state_nxt = ST_MEM;
                    else                                           state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: if (!i_stall) state_nxt = ST_F1;
            ST_MEM: begin
                if (xfer)     state_nxt = (cls == CLS_LOAD) ? ST_WB : ST_F1;
                else if (tmo) state_nxt = ST_ERR;
            end
            ST_WB:   if (!i_stall) state_nxt = ST_F1;
            ST_HALT: state_nxt = ST_HALT;
            ST_ERR:  state_nxt = ST_ERR;
            default: state_nxt = ST_ERR;
        endcase
    end

    always_comb begin
        o_mem_req = req_raw && !i_stall;
        o_pc_inc  = xfer && (state == ST_F1 || state == ST_F2);
        o_mem_rd  = 1'b0;
        o_mem_wr  = 1'b0;
        o_state   = state;
        o_err     = (state == ST_ERR);
        o_halt    = (state == ST_HALT);
        o_alu_op  = '0;
        o_s1      = '0;
        o_s2      = '0;
        o_dest    = '0;
        o_imm     = '0;
        o_reg_we  = 1'b0;
        case (state)
            ST_EXEC: begin
                o_alu_op = OP_W'(func);
                o_s1     = s1;
                o_s2     = s2_is_imm(cls) ? {REG_W{1'b1}} : ir2[REG_W-1:0];
                o_dest   = dest;
                o_imm    = ir2;
                o_reg_we = !i_stall;
            end
            ST_MEM: begin
                o_mem_rd = (cls == CLS_LOAD) && !i_stall;
                o_mem_wr = (cls == CLS_STORE) && !i_stall;
                o_imm    = ir2;
                if (cls == CLS_STORE) o_s1 = s1;
            end
            ST_WB: begin
                o_dest   = dest;
                o_reg_we = !i_stall;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer with TIMEOUT=3; expected values are hand-derived.
module tb_inst_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_mem_rdy = 1'b0;
    logic [15:0] i_mem_data = '0;
    logic        o_mem_req, o_mem_rd, o_mem_wr, o_pc_inc, o_err, o_halt, o_reg_we;
    logic [3:0]  o_state;
    logic [5:0]  o_alu_op;
    logic [3:0]  o_s1, o_s2, o_dest;
    logic [15:0] o_imm;

    int vec_cnt = 0;
    int miscmp_cnt = 0;

    inst_sequencer #(.DATA_W(16), .REG_W(4), .OP_W(6), .TIMEOUT(3)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_stall    (i_stall),
        .i_mem_rdy  (i_mem_rdy),
        .i_mem_data (i_mem_data),
        .o_mem_req  (o_mem_req),
        .o_mem_rd   (o_mem_rd),
        .o_mem_wr   (o_mem_wr),
        .o_pc_inc   (o_pc_inc),
        .o_state    (o_state),
        .o_err      (o_err),
        .o_halt     (o_halt),
        .o_alu_op   (o_alu_op),
        .o_s1       (o_s1),
        .o_s2       (o_s2),
        .o_dest     (o_dest),
        .o_imm      (o_imm),
        .o_reg_we   (o_reg_we)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1ns later.
    task automatic drive(input logic rdy, input logic [15:0] dat, input logic stall);
        @(negedge i_clk);
        i_mem_rdy  = rdy;
        i_mem_data = dat;
        i_stall    = stall;
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_state"}, 32'(o_state), 32'd0);
        check_val({tag, "_strobes"},
                  32'({o_mem_req, o_mem_rd, o_mem_wr, o_pc_inc, o_err, o_halt, o_reg_we}), 32'd0);
        check_val({tag, "_sel"}, 32'({o_alu_op, o_s1, o_s2, o_dest, o_imm}), 32'd0);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge i_clk);
        i_rst_n    = 1'b0;
        i_mem_rdy  = 1'b0;
        i_mem_data = '0;
        i_stall    = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check_quiet(tag);
    endtask

    initial begin
        apply_reset("rst0");

        // NOP: F1 -> DEC -> F1
        drive(1'b1, 16'h0000, 1'b0);
        check_val("nop_f1_state", 32'(o_state), 32'd1);
        check_val("nop_f1_req_pcinc", 32'({o_mem_req, o_pc_inc}), 32'b11);
        drive(1'b1, 16'h0000, 1'b0);
        check_val("nop_dec_state", 32'(o_state), 32'd3);
        check_val("nop_dec_quiet", 32'({o_mem_req, o_pc_inc, o_reg_we}), 32'd0);

        // ALU_RR 0x1A21 / 0x0003
        drive(1'b1, 16'h1A21, 1'b0);
        check_val("rr_f1_state", 32'(o_state), 32'd1);
        drive(1'b1, 16'h0003, 1'b0);
        check_val("rr_f2_state", 32'(o_state), 32'd2);
        check_val("rr_f2_pcinc", 32'(o_pc_inc), 32'd1);
        drive(1'b0, 16'h0000, 1'b0);
        check_val("rr_dec_state", 32'(o_state), 32'd3);
        drive(1'b0, 16'h0000, 1'b0);
        check_val("rr_exec_state", 32'(o_state), 32'd4);
        check_val("rr_exec_sel", 32'({o_alu_op, o_dest, o_s1, o_s2}), 32'({6'h0A, 4'd2, 4'd1, 4'd3}));
        check_val("rr_exec_we_req", 32'({o_reg_we, o_mem_req}), 32'b10);

        // LOAD 0x3050 / 0x1234 with two wait cycles in MEM
        drive(1'b1, 16'h3050, 1'b0);
        check_val("rr_total_f1", 32'(o_state), 32'd1);
        drive(1'b1, 16'h1234, 1'b0);
        check_val("ld_f2_state", 32'(o_state), 32'd2);
        drive(1'b0, 16'h0000, 1'b0);
        check_val("ld_dec_state", 32'(o_state), 32'd3);
        for (int i = 0; i < 3; i++) begin
            drive(i == 2, 16'h0000, 1'b0);
            check_val($sformatf("ld_mem%0d_state", i), 32'(o_state), 32'd5);
            check_val($sformatf("ld_mem%0d_rdwr", i), 32'({o_mem_req, o_mem_rd, o_mem_wr}), 32'b110);
            check_val($sformatf("ld_mem%0d_imm", i), 32'(o_imm), 32'h1234);
        end
        drive(1'b0, 16'h0000, 1'b0);
        check_val("ld_wb_state", 32'(o_state), 32'd6);
        check_val("ld_wb_dest_we", 32'({o_dest, o_reg_we, o_mem_req}), 32'({4'd5, 1'b1, 1'b0}));

        // STORE 0x4017 / 0x00AB with a 4-cycle stall inside MEM
        drive(1'b1, 16'h4017, 1'b0);
        check_val("st_f1_state", 32'(o_state), 32'd1);
        drive(1'b1, 16'h00AB, 1'b0);
        drive(1'b0, 16'h0000, 1'b0);
        check_val("st_dec_state", 32'(o_state), 32'd3);
        drive(1'b0, 16'h0000, 1'b0);
        check_val("st_mem_wr", 32'({o_state, o_mem_req, o_mem_rd, o_mem_wr}), 32'({4'd5, 3'b101}));
        check_val("st_mem_sel", 32'({o_s1, o_imm}), 32'({4'd7, 16'h00AB}));
        for (int i = 0; i < 4; i++) begin
            drive(i == 3, 16'h0000, 1'b1);
            check_val($sformatf("st_stall%0d_state", i), 32'(o_state), 32'd5);
            check_val($sformatf("st_stall%0d_gated", i),
                      32'({o_mem_req, o_mem_rd, o_mem_wr, o_pc_inc, o_reg_we}), 32'd0);
            check_val($sformatf("st_stall%0d_sel", i), 32'({o_s1, o_imm}), 32'({4'd7, 16'h00AB}));
        end
        drive(1'b0, 16'h0000, 1'b0);
        check_val("st_after_stall_state", 32'(o_state), 32'd5);
        drive(1'b1, 16'h0000, 1'b0);
        check_val("st_xfer_wr", 32'({o_state, o_mem_wr}), 32'({4'd5, 1'b1}));

        // Timeout: rdy rising on the 3rd wait edge is accepted
        drive(1'b0, 16'h0000, 1'b0);
        check_val("to_acc_w1", 32'(o_state), 32'd1);
        drive(1'b0, 16'h0000, 1'b0);
        check_val("to_acc_w2", 32'(o_state), 32'd1);
        drive(1'b1, 16'h0000, 1'b0);
        check_val("to_acc_w3", 32'({o_state, o_pc_inc}), 32'({4'd1, 1'b1}));
        drive(1'b0, 16'h0000, 1'b0);
        check_val("to_acc_dec", 32'({o_state, o_err}), 32'({4'd3, 1'b0}));

        // Timeout: three unanswered wait cycles -> ERR
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h0000, 1'b0);
            check_val($sformatf("to_wait%0d", i), 32'(o_state), 32'd1);
        end
        drive(1'b0, 16'h0000, 1'b0);
        check_val("to_err", 32'({o_state, o_err, o_mem_req}), 32'({4'd8, 1'b1, 1'b0}));
        drive(1'b1, 16'h0000, 1'b1);
        check_val("to_err_sticky", 32'({o_state, o_err, o_mem_req}), 32'({4'd8, 1'b1, 1'b0}));

        // HALT
        apply_reset("rst1");
        drive(1'b1, 16'hF000, 1'b0);
        check_val("halt_f1_state", 32'(o_state), 32'd1);
        drive(1'b1, 16'h0000, 1'b0);
        check_val("halt_dec_state", 32'(o_state), 32'd3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0000, 1'b0);
            check_val($sformatf("halt%0d", i), 32'({o_state, o_halt, o_err, o_mem_req}),
                      32'({4'd7, 3'b100}));
        end

        // Illegal class 0x7
        apply_reset("rst2");
        drive(1'b1, 16'h7000, 1'b0);
        check_val("ill_f1_state", 32'(o_state), 32'd1);
        drive(1'b1, 16'h0000, 1'b0);
        check_val("ill_dec_state", 32'(o_state), 32'd3);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'h0000, 1'b0);
            check_val($sformatf("ill_err%0d", i), 32'({o_state, o_err, o_halt, o_mem_req}),
                      32'({4'd8, 3'b100}));
        end

        // Asynchronous reset in the middle of F2
        apply_reset("rst3");
        drive(1'b1, 16'h1A21, 1'b0);
        drive(1'b0, 16'h0000, 1'b0);
        check_val("mid_f2_state", 32'({o_state, o_mem_req}), 32'({4'd2, 1'b1}));
        #2;
        i_rst_n = 1'b0;
        #1;
        check_quiet("mid_rst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check_quiet("mid_rel");
        drive(1'b0, 16'h0000, 1'b0);
        check_val("mid_restart", 32'({o_state, o_mem_req, o_reg_we, o_pc_inc}), 32'({4'd1, 3'b100}));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
